// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default bus widths, the NOP word and the opcode constants decode relies on.
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;

    // Sequencer states: one idle cycle after reset, then running until the
    // last program word has been loaded into the output slot.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    // Opcodes live in the top six bits of the instruction word.
    localparam logic [5:0] InstLLI = 6'd1;
    localparam logic [5:0] InstBEQ = 6'd4;
    localparam logic [5:0] InstBNE = 6'd5;

    // Opcode zero with an all-zero body executes as a no-op.
    localparam logic [INST_W_DEF-1:0] NOP_WORD = {6'd0, 26'd0};

endpackage

// File: rtl/inst_fetch_seq.sv
// Program-counter sequencer in front of the instruction ROM.
// Drives the ROM address from the PC register, captures the returned word into a
// one-entry valid/ready slot, and applies skip / absolute-jump redirects coming
// back from execute. Fetching stops once the last program word is loaded.
// Optional build macro FETCH_PERF_CNT_EN adds a saturating retired-instruction
// counter on port retire_cnt_o.
module inst_fetch_seq
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INST_W   = INST_W_DEF,
    parameter int PROG_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              skip_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       retire_cnt_o,
`endif
    output logic              done_o
);

    // Any PC at or beyond the last program word sends the sequencer to HALT
    // once that word has been loaded (out-of-range words read back as NOP).
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] last_pc_reg;
    logic [INST_W-1:0] inst_reg;
    logic [ADDR_W-1:0] inst_pc_reg;
    logic              valid_reg;

    logic redirect;
    logic accept;
    logic slot_free;

    // Redirects are ignored during the boot cycle; a redirected slot is never
    // counted as accepted even when the consumer signals ready.
    assign redirect  = (skip_i | jump_i) && (state_reg != S_BOOT);
    assign accept    = valid_reg & inst_ready_i & ~(skip_i | jump_i);
    assign slot_free = ~valid_reg | inst_ready_i;

    // Sequencer FSM: PC update, output slot and last-accepted PC tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_BOOT;
            pc_reg      <= '0;
            last_pc_reg <= '0;
            inst_reg    <= INST_W'(NOP_WORD);
            inst_pc_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_BOOT: begin
                    state_reg <= S_RUN;
                end
                default: begin
                    if (redirect) begin
                        // Squash the slot; fetch resumes from the new PC next cycle.
                        valid_reg <= 1'b0;
                        pc_reg    <= jump_i ? jump_addr_i : last_pc_reg + ADDR_W'(2);
                        state_reg <= S_RUN;
                    end else begin
                        if (accept) begin
                            last_pc_reg <= inst_pc_reg;
                        end
                        if ((state_reg == S_RUN) && slot_free) begin
                            inst_reg    <= rom_inst_i;
                            inst_pc_reg <= pc_reg;
                            valid_reg   <= 1'b1;
                            pc_reg      <= pc_reg + ADDR_W'(1);
                            if (pc_reg >= LAST_ADDR) begin
                                state_reg <= S_HALT;
                            end
                        end else if (inst_ready_i) begin
                            valid_reg <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_cnt_reg;

    // Saturating count of accepted instructions; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_reg <= '0;
        end else if (accept && (retire_cnt_reg != 32'hFFFF_FFFF)) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt_o = retire_cnt_reg;
`endif

    assign rom_addr_o   = pc_reg;
    assign inst_o       = inst_reg;
    assign inst_pc_o    = inst_pc_reg;
    assign inst_valid_o = valid_reg;
    assign done_o       = (state_reg == S_HALT) && !valid_reg;

endmodule
